puck_motion_ctl: RTL and testbench

//  Frame-rate puck motion controller. Owns the puck position fed to the puck renderer
//  (xpos_ball/ypos_ball of the draw stage) and its velocity.

---
 rtl/puck_motion_ctl.sv | 178 +++++++++++++++++
 tb/tb_puck_motion_ctl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/puck_motion_ctl.sv
// Frame-rate puck motion controller: moves the puck once per vsync, bounces it
// off the table walls, applies paddle kicks and detects goals.
module puck_motion_ctl #(
   parameter int unsigned XMAX        = 1023,
   parameter int unsigned YMAX        = 767,
   parameter int unsigned RADIUS_BALL = 10,
   parameter int unsigned START_X     = 512,
   parameter int unsigned START_Y     = 384,
   parameter int unsigned GOAL_YMIN   = 284,
   parameter int unsigned GOAL_YMAX   = 484,
   parameter int unsigned VMAX        = 15,
   parameter int unsigned GOAL_PAUSE  = 60
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              vsync_in,
   input  logic              start,
   input  logic              hit,
   input  logic signed [7:0] hit_vx,
   input  logic signed [7:0] hit_vy,
   output logic [11:0]       xpos_ball,
   output logic [11:0]       ypos_ball,
   output logic              goal_left,
   output logic              goal_right,
   output logic              running
);

   localparam int unsigned POS_W = 12;
   localparam int unsigned VEL_W = 8;
   localparam int unsigned CNT_W = $clog2(GOAL_PAUSE);

   localparam logic signed [POS_W:0]   LO_S   = (POS_W+1)'(RADIUS_BALL);
   localparam logic signed [POS_W:0]   X_HI_S = (POS_W+1)'(XMAX - RADIUS_BALL);
   localparam logic signed [POS_W:0]   Y_HI_S = (POS_W+1)'(YMAX - RADIUS_BALL);
   localparam logic signed [VEL_W-1:0] VMAX_S = VEL_W'(VMAX);
   localparam logic signed [VEL_W-1:0] SERVE_VX = VEL_W'(2);
   localparam logic signed [VEL_W-1:0] SERVE_VY = VEL_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, GOAL_WAIT} state_t;

   state_t                   state_q, state_d;
   logic [POS_W-1:0]         x_q, x_d, y_q, y_d;
   logic signed [VEL_W-1:0]  vx_q, vx_d, vy_q, vy_d;
   logic signed [VEL_W-1:0]  pend_vx_q, pend_vx_d, pend_vy_q, pend_vy_d;
   logic                     hit_pend_q, hit_pend_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     vsync_d;
   logic                     goal_left_d, goal_right_d;

   function automatic logic signed [VEL_W-1:0] clamp_v(input logic signed [VEL_W-1:0] v);
      if (v > VMAX_S)  return VMAX_S;
      if (v < -VMAX_S) return -VMAX_S;
      return v;
   endfunction

   logic                    tick_c, hit_acc_c, use_pend_c;
   logic signed [VEL_W-1:0] hvx_c, hvy_c, vx_use_c, vy_use_c;
   logic signed [POS_W:0]   nx_c, ny_c;

   assign tick_c     = vsync_in & ~vsync_d;
   assign hit_acc_c  = hit & (state_q != GOAL_WAIT);
   assign hvx_c      = clamp_v(hit_vx);
   assign hvy_c      = clamp_v(hit_vy);
   assign use_pend_c = hit_acc_c | hit_pend_q;

   // A kick arriving in the tick cycle wins over an older pending one.
   always_comb begin
      vx_use_c = (state_q == IDLE) ? SERVE_VX : vx_q;
      vy_use_c = (state_q == IDLE) ? SERVE_VY : vy_q;
      if (use_pend_c) begin
         vx_use_c = hit_acc_c ? hvx_c : pend_vx_q;
         vy_use_c = hit_acc_c ? hvy_c : pend_vy_q;
      end
   end

   assign nx_c = $signed({1'b0, x_q}) + $signed({{(POS_W+1-VEL_W){vx_use_c[VEL_W-1]}}, vx_use_c});
   assign ny_c = $signed({1'b0, y_q}) + $signed({{(POS_W+1-VEL_W){vy_use_c[VEL_W-1]}}, vy_use_c});

   // Next-state and datapath update
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      vx_d         = vx_q;
      vy_d         = vy_q;
      pend_vx_d    = pend_vx_q;
      pend_vy_d    = pend_vy_q;
      hit_pend_d   = hit_pend_q;
      cnt_d        = cnt_q;
      goal_left_d  = 1'b0;
      goal_right_d = 1'b0;

      if (hit_acc_c) begin
         pend_vx_d  = hvx_c;
         pend_vy_d  = hvy_c;
         hit_pend_d = 1'b1;
      end

      if (tick_c && ((state_q == RUN) || (state_q == IDLE && start))) begin
         state_d    = RUN;
         hit_pend_d = 1'b0;
         vx_d       = vx_use_c;
         vy_d       = vy_use_c;

         if (ny_c < LO_S) begin
            y_d  = POS_W'(RADIUS_BALL);
            vy_d = -vy_use_c;
         end else if (ny_c > Y_HI_S) begin
            y_d  = POS_W'(YMAX - RADIUS_BALL);
            vy_d = -vy_use_c;
         end else begin
            y_d = ny_c[POS_W-1:0];
         end

         if ((nx_c < LO_S) || (nx_c > X_HI_S)) begin
            // Goal mouth is judged against the post-bounce y
            if ((y_d >= POS_W'(GOAL_YMIN)) && (y_d <= POS_W'(GOAL_YMAX))) begin
               goal_left_d  = (nx_c < LO_S);
               goal_right_d = (nx_c > X_HI_S);
               state_d      = GOAL_WAIT;
               x_d          = POS_W'(START_X);
               y_d          = POS_W'(START_Y);
               vx_d         = '0;
               vy_d         = '0;
               cnt_d        = '0;
            end else begin
               x_d  = (nx_c < LO_S) ? POS_W'(RADIUS_BALL) : POS_W'(XMAX - RADIUS_BALL);
               vx_d = -vx_use_c;
            end
         end else begin
            x_d = nx_c[POS_W-1:0];
         end
      end else if (tick_c && state_q == GOAL_WAIT) begin
         if (cnt_q == CNT_W'(GOAL_PAUSE - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q    <= IDLE;
         x_q        <= POS_W'(START_X);
         y_q        <= POS_W'(START_Y);
         vx_q       <= '0;
         vy_q       <= '0;
         pend_vx_q  <= '0;
         pend_vy_q  <= '0;
         hit_pend_q <= 1'b0;
         cnt_q      <= '0;
         vsync_d    <= 1'b0;
         goal_left  <= 1'b0;
         goal_right <= 1'b0;
         running    <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         vx_q       <= vx_d;
         vy_q       <= vy_d;
         pend_vx_q  <= pend_vx_d;
         pend_vy_q  <= pend_vy_d;
         hit_pend_q <= hit_pend_d;
         cnt_q      <= cnt_d;
         vsync_d    <= vsync_in;
         goal_left  <= goal_left_d;
         goal_right <= goal_right_d;
         running    <= (state_d == RUN);
      end
   end

   assign xpos_ball = x_q;
   assign ypos_ball = y_q;

endmodule

// File: tb/tb_puck_motion_ctl.sv
// Directed bench for puck_motion_ctl: serve, wall bounces, corner, kick clamping,
// goals on both sides, goal pause length and mid-run reset.
module tb_puck_motion_ctl;

   logic              clk_in = 1'b0;
   logic              rst = 1'b1;
   logic              vsync_in = 1'b0;
   logic              start = 1'b0;
   logic              hit = 1'b0;
   logic signed [7:0] hit_vx = '0;
   logic signed [7:0] hit_vy = '0;
   logic [11:0]       xpos_ball, ypos_ball;
   logic              goal_left, goal_right, running;

   int errors = 0;
   int checks = 0;
   logic gl_b, gl_c, gr_b, gr_c;

   puck_motion_ctl dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .vsync_in   (vsync_in),
      .start      (start),
      .hit        (hit),
      .hit_vx     (hit_vx),
      .hit_vy     (hit_vy),
      .xpos_ball  (xpos_ball),
      .ypos_ball  (ypos_ball),
      .goal_left  (goal_left),
      .goal_right (goal_right),
      .running    (running)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_pos(input string tag, input int ex, input int ey, input logic er);
      chk({tag, ".x"}, 32'(xpos_ball), 32'(ex));
      chk({tag, ".y"}, 32'(ypos_ball), 32'(ey));
      chk({tag, ".run"}, 32'(running), 32'(er));
   endtask

   // One frame tick; goal outputs captured one and two cycles after the tick edge
   task automatic do_tick(input logic st);
      @(negedge clk_in); vsync_in = 1'b1; start = st;
      @(negedge clk_in); vsync_in = 1'b0;
      gl_b = goal_left; gr_b = goal_right;
      @(negedge clk_in); start = 1'b0;
      gl_c = goal_left; gr_c = goal_right;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) do_tick(1'b0);
   endtask

   task automatic do_hit(input logic signed [7:0] vx, input logic signed [7:0] vy);
      @(negedge clk_in); hit = 1'b1; hit_vx = vx; hit_vy = vy;
      @(negedge clk_in); hit = 1'b0;
   endtask

   task automatic tick_hit(input logic signed [7:0] vx, input logic signed [7:0] vy);
      @(negedge clk_in); vsync_in = 1'b1; hit = 1'b1; hit_vx = vx; hit_vy = vy;
      @(negedge clk_in); vsync_in = 1'b0; hit = 1'b0;
      @(negedge clk_in);
   endtask

   initial begin
      repeat (3) @(negedge clk_in);
      rst = 1'b0;
      @(negedge clk_in);
      chk_pos("reset", 512, 384, 1'b0);
      chk("reset.gl", 32'(goal_left), 32'd0);
      chk("reset.gr", 32'(goal_right), 32'd0);

      // start without a frame tick does nothing
      start = 1'b1;
      repeat (4) @(negedge clk_in);
      start = 1'b0;
      chk_pos("no_tick", 512, 384, 1'b0);

      // serve and straight run
      do_tick(1'b1);
      chk_pos("serve", 514, 385, 1'b1);
      ticks(3);
      chk_pos("run3", 520, 388, 1'b1);

      // walk to x=1010, y=100 then bounce off right wall outside goal
      do_hit(8'sd0, -8'sd12); ticks(24);
      chk_pos("walk_y", 520, 100, 1'b1);
      do_hit(8'sd15, 8'sd0); ticks(32);
      do_hit(8'sd10, 8'sd0); do_tick(1'b0);
      chk_pos("walk_x", 1010, 100, 1'b1);
      do_hit(8'sd8, 8'sd0); do_tick(1'b0);
      chk_pos("rwall", 1013, 100, 1'b1);
      chk("rwall.gr", 32'(gr_b), 32'd0);
      do_tick(1'b0);
      chk_pos("rwall_back", 1005, 100, 1'b1);
      repeat (5) @(negedge clk_in);
      chk_pos("hold", 1005, 100, 1'b1);

      // walk to corner 12,12 and bounce both axes
      do_hit(-8'sd15, -8'sd11); ticks(8);
      chk_pos("to_y12", 885, 12, 1'b1);
      do_hit(-8'sd15, 8'sd0); ticks(58);
      do_hit(-8'sd3, 8'sd0); do_tick(1'b0);
      chk_pos("at_corner", 12, 12, 1'b1);
      do_hit(-8'sd5, -8'sd5); do_tick(1'b0);
      chk_pos("corner", 10, 10, 1'b1);
      do_tick(1'b0);
      chk_pos("corner_back", 15, 15, 1'b1);

      // kick in the tick cycle, clamped to -15, bounces off left wall
      tick_hit(-8'sd40, 8'sd3);
      chk_pos("kick_clamp", 10, 18, 1'b1);
      do_tick(1'b0);
      chk_pos("kick_back", 25, 21, 1'b1);

      // positive clamp on vy, then walk to x=14, y=384
      do_hit(8'sd0, 8'sd100); ticks(24);
      chk_pos("vy_clamp", 25, 381, 1'b1);
      do_hit(8'sd0, 8'sd3); do_tick(1'b0);
      do_hit(-8'sd11, 8'sd0); do_tick(1'b0);
      chk_pos("pre_goal", 14, 384, 1'b1);

      // left goal
      do_hit(-8'sd6, 8'sd0); do_tick(1'b0);
      chk("goal_l.pulse", 32'(gl_b), 32'd1);
      chk("goal_l.gone", 32'(gl_c), 32'd0);
      chk("goal_l.gr", 32'(gr_b), 32'd0);
      chk_pos("goal_l", 512, 384, 1'b0);

      // kick during pause is dropped; pause lasts exactly 60 ticks
      do_hit(8'sd5, 8'sd5);
      ticks(59);
      chk_pos("pause59", 512, 384, 1'b0);
      do_tick(1'b1);
      chk_pos("pause60", 512, 384, 1'b0);
      do_tick(1'b1);
      chk_pos("reserve", 514, 385, 1'b1);

      // right goal
      do_hit(8'sd15, 8'sd0); ticks(33);
      chk_pos("pre_goal_r", 1009, 385, 1'b1);
      do_tick(1'b0);
      chk("goal_r.pulse", 32'(gr_b), 32'd1);
      chk("goal_r.gone", 32'(gr_c), 32'd0);
      chk("goal_r.gl", 32'(gl_b), 32'd0);
      chk_pos("goal_r", 512, 384, 1'b0);
      ticks(60);
      do_tick(1'b1);
      chk_pos("serve3", 514, 385, 1'b1);

      // reset mid-run at x=700
      do_hit(8'sd15, 8'sd0); ticks(12);
      do_hit(8'sd6, 8'sd0); do_tick(1'b0);
      chk_pos("x700", 700, 385, 1'b1);
      @(negedge clk_in); rst = 1'b1;
      @(negedge clk_in); rst = 1'b0;
      chk_pos("rst_run", 512, 384, 1'b0);
      do_tick(1'b0);
      chk_pos("rst_idle", 512, 384, 1'b0);
      do_tick(1'b1);
      chk_pos("rst_serve", 514, 385, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
